// File: rtl/fuzz_pkg.sv
// Shared types and constants for the 6502 fuzz memory: FSM states, LFSR taps,
// substitute opcodes and the documented-NMOS-opcode legality check.
package fuzz_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_DRAW
    } fuzz_state_e;

    // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam logic [7:0] OP_PHP     = 8'h08;
    localparam logic [7:0] OP_STY_ABS = 8'h8C;
    localparam logic [7:0] OP_STX_ABS = 8'h8E;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] NOP_OPCODE = 8'hEA;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic [7:0] store_opcode(input logic [1:0] sel);
        logic [7:0] op;
        case (sel)
            2'b11:   op = OP_PHP;
            2'b10:   op = OP_STY_ABS;
            2'b01:   op = OP_STX_ABS;
            default: op = OP_STA_ABS;
        endcase
        return op;
    endfunction

    // Decoded by low-nibble column; xxxx_xx11 columns (3/7/B/F) hold nothing documented
    function automatic logic is_legal_6502(input logic [7:0] op);
        logic [3:0] hi;
        logic       ok;
        hi = op[7:4];
        case (op[3:0])
            4'h0:                         ok = (hi != 4'h8);
            4'h1, 4'h5, 4'h6, 4'h8, 4'hD: ok = 1'b1;
            4'h2:                         ok = (hi == 4'hA);
            4'h4:                         ok = hi inside {4'h2, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
            4'h9:                         ok = (hi != 4'h8);
            4'hA:                         ok = !hi[0] || (hi == 4'h9) || (hi == 4'hB);
            4'hC:                         ok = hi inside {4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hB, 4'hC, 4'hE};
            4'hE:                         ok = (hi != 4'h9);
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fuzz_log_fifo.sv
// Synchronous FIFO carrying write-log entries; a push while full is dropped
// unless a pop frees a slot in the same cycle.
module fuzz_log_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + (do_push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (do_pop ? AW'(1) : AW'(0));
        count_d  = count_q + (do_push ? (AW+1)'(1) : '0) - (do_pop ? (AW+1)'(1) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/cpu_fuzz_mem.sv
// Random-stimulus 6502 system memory: self-fills from an LFSR, swaps illegal
// opcode fetches for random legal ones. Write log present when FUZZ_WRITE_LOG_EN is defined.
module cpu_fuzz_mem
    import fuzz_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter logic [31:0] SEED       = 32'hACE1_0001,
    parameter int          STORE_BIAS = 50,
    parameter int          MAX_TRIES  = 8,
    parameter int          LOG_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        din,
    input  logic              rnw,
    input  logic              sync,
    input  logic              phi2,
    output logic [7:0]        dout,
    output logic              ready,
    output logic              init_done,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [ADDR_W-1:0] log_addr,
    output logic [7:0]        log_data,
    output logic              log_overflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TRY_W = $clog2(MAX_TRIES + 2);

    fuzz_state_e       state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [ADDR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [ADDR_W-1:0] draw_addr_q, draw_addr_d;
    logic [TRY_W-1:0]  try_q, try_d;
    logic [7:0]        dout_q, dout_d;
    logic              init_done_q, init_done_d;

    logic [7:0]        mem [DEPTH];
    logic [7:0]        mem_rd, draw, draw_op;
    logic              draw_ok, fetch_illegal, fill_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              log_push, log_stall;
    logic [ADDR_W+7:0] log_entry;

    assign mem_rd        = mem[addr];
    assign draw          = lfsr_q[7:0];
    assign lfsr_d        = lfsr_next(lfsr_q);
    assign fill_last     = (fill_ptr_q == '1);
    assign fetch_illegal = phi2 && rnw && sync && !is_legal_6502(mem_rd);

    // Fallback wins once MAX_TRIES draws have been rejected
    always_comb begin
        draw_ok = 1'b0;
        draw_op = draw;
        if (try_q == TRY_W'(MAX_TRIES)) begin
            draw_ok = 1'b1;
            draw_op = NOP_OPCODE;
        end else if (int'(draw) < STORE_BIAS) begin
            draw_ok = 1'b1;
            draw_op = store_opcode(draw[1:0]);
        end else if (is_legal_6502(draw)) begin
            draw_ok = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FILL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (fill_last) state_d = ST_RUN;
            ST_RUN:  if (fetch_illegal) state_d = ST_DRAW;
            ST_DRAW: if (draw_ok) state_d = ST_RUN;
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        ready       = (state_q == ST_RUN) && !log_stall;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = din;
        log_push    = 1'b0;
        log_entry   = {addr, din};
        dout_d      = dout_q;
        fill_ptr_d  = fill_ptr_q;
        init_done_d = init_done_q;
        try_d       = try_q;
        draw_addr_d = draw_addr_q;
        case (state_q)
            ST_FILL: begin
                mem_we     = 1'b1;
                mem_waddr  = fill_ptr_q;
                mem_wdata  = draw;
                fill_ptr_d = fill_ptr_q + ADDR_W'(1);
                if (fill_last) init_done_d = 1'b1;
            end
            ST_RUN: begin
                if (phi2 && !rnw) begin
                    mem_we   = 1'b1;
                    log_push = 1'b1;
                end else if (fetch_illegal) begin
                    try_d       = '0;
                    draw_addr_d = addr;
                end else if (phi2) begin
                    dout_d = mem_rd;
                end
            end
            ST_DRAW: begin
                if (draw_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = draw_addr_q;
                    mem_wdata = draw_op;
                    dout_d    = draw_op;
                    log_push  = 1'b1;
                    log_entry = {draw_addr_q, draw_op};
                end else begin
                    try_d = try_q + TRY_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q      <= SEED;
            fill_ptr_q  <= '0;
            draw_addr_q <= '0;
            try_q       <= '0;
            dout_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            fill_ptr_q  <= fill_ptr_d;
            draw_addr_q <= draw_addr_d;
            try_q       <= try_d;
            dout_q      <= dout_d;
            init_done_q <= init_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign dout      = dout_q;
    assign init_done = init_done_q;

`ifdef FUZZ_WRITE_LOG_EN
    localparam int CNT_W = $clog2(LOG_DEPTH) + 1;

    logic [ADDR_W+7:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, log_pop;
    logic              overflow_q, overflow_d;

    fuzz_log_fifo #(
        .WIDTH (ADDR_W + 8),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (log_push),
        .wdata (log_entry),
        .pop   (log_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign log_pop    = !fifo_empty && log_ready;
    // Stall one slot early so the CPU's in-flight write still has room
    assign log_stall  = (fifo_count >= CNT_W'(LOG_DEPTH - 1));
    assign overflow_d = overflow_q || (log_push && fifo_full && !log_pop);

    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign log_valid    = !fifo_empty;
    assign log_addr     = fifo_empty ? '0 : fifo_rdata[ADDR_W+7:8];
    assign log_data     = fifo_empty ? '0 : fifo_rdata[7:0];
    assign log_overflow = overflow_q;
`else
    logic unused_log;
    assign unused_log   = ^{log_ready, log_push, log_entry};
    assign log_stall    = 1'b0;
    assign log_valid    = 1'b0;
    assign log_addr     = '0;
    assign log_data     = '0;
    assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_fuzz_mem.sv
// Randomized bench for cpu_fuzz_mem: two instances (default bias, and a
// store-free low-retry one for the NOP fallback) against an opcode-level model.
module tb_cpu_fuzz_mem;

`ifdef FUZZ_WRITE_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif
    localparam int          LOG_DEPTH_A = 4;
    localparam logic [31:0] SEED_A      = 32'h0000_0001;
    localparam logic [31:0] SEED_B      = 32'h1234_5678;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] addr_s [2];
    logic [7:0] din_s  [2];
    logic       rnw_s  [2];
    logic       sync_s [2];
    logic       phi2_s [2];
    logic [7:0] dout_s [2];
    logic       ready_s[2];
    logic       idone_s[2];

    logic       log_ready_a = 1'b0;
    logic       log_valid_a, log_overflow_a;
    logic [3:0] log_addr_a;
    logic [7:0] log_data_a;
    logic       unused_lv_b, unused_ovf_b;
    logic [3:0] unused_la_b;
    logic [7:0] unused_ld_b;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] m_lfsr [2];
    logic [7:0]  m_mem  [2][16];
    logic [11:0] exp_log[$];
    logic        m_ovf = 1'b0;

    always #5 clk = ~clk;

    cpu_fuzz_mem #(.ADDR_W(4), .SEED(SEED_A), .LOG_DEPTH(LOG_DEPTH_A)) dut_a (
        .clk(clk), .reset(reset), .addr(addr_s[0]), .din(din_s[0]), .rnw(rnw_s[0]),
        .sync(sync_s[0]), .phi2(phi2_s[0]), .dout(dout_s[0]), .ready(ready_s[0]),
        .init_done(idone_s[0]), .log_valid(log_valid_a), .log_ready(log_ready_a),
        .log_addr(log_addr_a), .log_data(log_data_a), .log_overflow(log_overflow_a));

    cpu_fuzz_mem #(.ADDR_W(4), .SEED(SEED_B), .STORE_BIAS(0), .MAX_TRIES(3)) dut_b (
        .clk(clk), .reset(reset), .addr(addr_s[1]), .din(din_s[1]), .rnw(rnw_s[1]),
        .sync(sync_s[1]), .phi2(phi2_s[1]), .dout(dout_s[1]), .ready(ready_s[1]),
        .init_done(idone_s[1]), .log_valid(unused_lv_b), .log_ready(1'b1),
        .log_addr(unused_la_b), .log_data(unused_ld_b), .log_overflow(unused_ovf_b));

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // The LFSR advances every cycle and reloads its seed under reset
    always @(posedge clk) begin
        m_lfsr[0] <= reset ? SEED_A : step(m_lfsr[0]);
        m_lfsr[1] <= reset ? SEED_B : step(m_lfsr[1]);
    end

    function automatic bit legal_m(input logic [7:0] b);
        if (b[1:0] == 2'b11) return 1'b0;
        if (b inside {8'h80, 8'h89, 8'h9C, 8'h9E}) return 1'b0;
        if (b[3:0] == 4'h2 && b != 8'hA2) return 1'b0;
        if (b inside {8'h04, 8'h14, 8'h34, 8'h44, 8'h54, 8'h64, 8'h74, 8'hD4, 8'hF4,
                      8'h0C, 8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'hDC, 8'hFC,
                      8'h1A, 8'h3A, 8'h5A, 8'h7A, 8'hDA, 8'hFA}) return 1'b0;
        return 1'b1;
    endfunction

    // Substitute opcode and stall length for an illegal fetch taken while the LFSR holds l
    function automatic void predict(input logic [31:0] l0, input int bias, input int tries,
                                    output logic [7:0] op, output int stalls);
        logic [7:0]  stab [4];
        logic [31:0] l;
        stab = '{8'h8D, 8'h8E, 8'h8C, 8'h08};
        l = l0;
        op = 8'hEA;
        stalls = tries + 1;
        for (int k = 1; k <= tries + 1; k++) begin
            l = step(l);
            if (k == tries + 1) begin op = 8'hEA; stalls = k; return; end
            if (int'(l[7:0]) < bias) begin op = stab[l[1:0]]; stalls = k; return; end
            if (legal_m(l[7:0])) begin op = l[7:0]; stalls = k; return; end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void log_model(input int u, input logic [3:0] a, input logic [7:0] d);
        if (u == 0 && LOG_EN) begin
            if (exp_log.size() >= LOG_DEPTH_A) m_ovf = 1'b1;
            else exp_log.push_back({a, d});
        end
    endfunction

    // One CPU access on instance u; reads wait out any substitution stall
    task automatic access(input int u, input logic [3:0] a, input logic wr,
                          input logic [7:0] d, input logic sy);
        logic [7:0] op;
        int         stalls, seen;
        addr_s[u] = a; din_s[u] = d; rnw_s[u] = !wr; sync_s[u] = sy; phi2_s[u] = 1'b1;
        if (wr) begin
            m_mem[u][a] = d;
            log_model(u, a, d);
            @(negedge clk);
            phi2_s[u] = 1'b0;
            return;
        end
        if (sy && !legal_m(m_mem[u][a])) predict(m_lfsr[u], (u == 0) ? 50 : 0, (u == 0) ? 8 : 3, op, stalls);
        else begin op = m_mem[u][a]; stalls = 0; end
        @(negedge clk);
        phi2_s[u] = 1'b0;
        seen = 0;
        while (ready_s[u] !== 1'b1 && seen < 20) begin seen++; @(negedge clk); end
        chk("stall_cycles", seen, stalls);
        chk("read_data", {24'h0, dout_s[u]}, {24'h0, op});
        if (stalls > 0) begin
            m_mem[u][a] = op;
            log_model(u, a, op);
        end
    endtask

    task automatic drain();
        logic [11:0] e;
        while (exp_log.size() > 0) begin
            e = exp_log.pop_front();
            chk("log_valid", log_valid_a, 1);
            chk("log_addr", log_addr_a, e[11:8]);
            chk("log_data", log_data_a, e[7:0]);
            log_ready_a = 1'b1;
            @(negedge clk);
            log_ready_a = 1'b0;
        end
        chk("log_empty", log_valid_a, 0);
        chk("log_overflow", log_overflow_a, m_ovf);
    endtask

    task automatic reset_and_fill();
        logic [31:0] l;
        int          cnt;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout_s[0], 0);
        chk("rst_ready", ready_s[0], 0);
        chk("rst_init_done", idone_s[0], 0);
        chk("rst_log_valid", log_valid_a, 0);
        chk("rst_log_addr", log_addr_a, 0);
        chk("rst_log_data", log_data_a, 0);
        chk("rst_log_overflow", log_overflow_a, 0);
        for (int u = 0; u < 2; u++) begin
            l = (u == 0) ? SEED_A : SEED_B;
            for (int i = 0; i < 16; i++) begin m_mem[u][i] = l[7:0]; l = step(l); end
        end
        exp_log.delete();
        m_ovf = 1'b0;
        reset = 1'b0;
        cnt = 0;
        while (idone_s[0] !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) chk("fill_ready", ready_s[0], 0);
        end
        chk("fill_cycles", cnt, 16);
        chk("fill_init_done_b", idone_s[1], 1);
        chk("run_ready", ready_s[0], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] op;
        int         st, n;
        for (int u = 0; u < 2; u++) begin
            addr_s[u] = '0; din_s[u] = '0; rnw_s[u] = 1'b1; sync_s[u] = 1'b0; phi2_s[u] = 1'b0;
        end
        @(negedge clk);
        reset_and_fill();

        for (int i = 0; i < 16; i++) access(0, 4'(i), 1'b0, 8'h00, 1'b0);

        // Legal fetch right after a write of the same byte: no stall, new data
        access(0, 4'd3, 1'b1, 8'hA9, 1'b0);
        drain();
        access(0, 4'd3, 1'b0, 8'h00, 1'b1);
        chk("legal_fetch", dout_s[0], 8'hA9);
        chk("legal_no_log", log_valid_a, 0);

        access(0, 4'd5, 1'b1, 8'hFF, 1'b0);
        drain();
        access(0, 4'd5, 1'b0, 8'h00, 1'b1);
        chk("subst_legal", legal_m(dout_s[0]) || dout_s[0] == 8'hEA, 1);
        drain();
        access(0, 4'd5, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       access(0, 4'($urandom_range(0, 15)), 1'b1, 8'($urandom), 1'b0);
                1:       access(0, 4'($urandom_range(0, 15)), 1'b0, 8'h00, 1'b0);
                default: access(0, 4'($urandom_range(0, 15)), 1'b0, 8'h00, 1'b1);
            endcase
            drain();
        end

        // Wait until the next three draws are all illegal, then fetch on the store-free instance
        access(1, 4'd5, 1'b1, 8'hFF, 1'b0);
        n = 0;
        predict(m_lfsr[1], 0, 3, op, st);
        while (st != 4 && n < 5000) begin
            @(negedge clk);
            n++;
            predict(m_lfsr[1], 0, 3, op, st);
        end
        access(1, 4'd5, 1'b0, 8'h00, 1'b1);
        chk("fallback_nop", dout_s[1], 8'hEA);

        for (int i = 0; i < 5; i++) begin
            access(0, 4'(8 + i), 1'b1, 8'(8'h10 + i), 1'b0);
            chk("bp_ready", ready_s[0], (exp_log.size() < LOG_DEPTH_A - 1) ? 1 : 0);
            chk("bp_overflow", log_overflow_a, m_ovf);
        end
        drain();
        repeat (3) @(negedge clk);
        chk("overflow_sticky", log_overflow_a, m_ovf);

        // Reset in the middle of a substitution stall
        access(0, 4'd7, 1'b1, 8'hFF, 1'b0);
        addr_s[0] = 4'd7; rnw_s[0] = 1'b1; sync_s[0] = 1'b1; phi2_s[0] = 1'b1;
        @(negedge clk);
        phi2_s[0] = 1'b0;
        chk("md_stall", ready_s[0], 0);
        reset = 1'b1;
        @(negedge clk);
        chk("md_init_done", idone_s[0], 0);
        chk("md_log_valid", log_valid_a, 0);
        chk("md_ready", ready_s[0], 0);
        chk("md_dout", dout_s[0], 0);
        reset_and_fill();
        for (int i = 0; i < 16; i++) access(0, 4'(i), 1'b0, 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
